// File: rtl/vga_pattern_gen_pkg.sv
// Shared constants for the VGA test-pattern renderer:
// default geometry, mode encodings and the colour-bar palette.
package vga_pkg;

  localparam int H_VIDEO_DEF = 640;
  localparam int V_VIDEO_DEF = 480;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_BOX   = 2'd3
  } mode_e;

  // {R,G,B} per bar, element 0 is the leftmost bar
  localparam logic [7:0][2:0] BAR_RGB = {
    3'b000,
    3'b001,
    3'b100,
    3'b101,
    3'b010,
    3'b011,
    3'b110,
    3'b111
  };

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Pixel-position / mode request in, DAC colour pins and frame pulse out.
// master = timing side, slave = renderer.
interface vga_pattern_gen_if #(
  parameter int COLOR_W = 1
);

  logic [9:0]         pixel_x;
  logic [9:0]         pixel_y;
  logic               video_on;
  logic [1:0]         mode_sel;
  logic [COLOR_W-1:0] red;
  logic [COLOR_W-1:0] green;
  logic [COLOR_W-1:0] blue;
  logic               frame_tick;

  modport master (
    output pixel_x,
    output pixel_y,
    output video_on,
    output mode_sel,
    input  red,
    input  green,
    input  blue,
    input  frame_tick
  );

  modport slave (
    input  pixel_x,
    input  pixel_y,
    input  video_on,
    input  mode_sel,
    output red,
    output green,
    output blue,
    output frame_tick
  );

endinterface

// File: rtl/vga_pattern_gen_box_mover.sv
// One axis of the bouncing box: position plus direction,
// stepping once per frame and clamping at 0 and LIMIT.
module vga_box_mover #(
  parameter int LIMIT = 608,
  parameter int STEP  = 4
) (
  input  logic        clk_0,
  input  logic        rst,
  input  logic        step_en,
  output logic [10:0] pos
);

  logic        dir;
  logic [10:0] up;

  assign up = pos + 11'(STEP);

  always_ff @(posedge clk_0) begin
    if (!rst) begin
      pos <= '0;
      dir <= 1'b1;
    end else if (step_en) begin
      if (dir) begin
        if (up >= 11'(LIMIT)) begin
          pos <= 11'(LIMIT);
          dir <= 1'b0;
        end else begin
          pos <= up;
        end
      end else begin
        // clamp before subtracting so pos never wraps
        if (pos <= 11'(STEP)) begin
          pos <= '0;
          dir <= 1'b1;
        end else begin
          pos <= pos - 11'(STEP);
        end
      end
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern renderer: solid, bars, checker, bouncing box.
// Mode and box position only change at the frame boundary.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_VIDEO    = H_VIDEO_DEF,
  parameter int V_VIDEO    = V_VIDEO_DEF,
  parameter int COLOR_W    = 1,
  parameter int CHECK_LOG2 = 4,
  parameter int BOX_SIZE   = 32,
  parameter int BOX_STEP   = 4
) (
  input logic              clk_0,
  input logic              rst,
  vga_pattern_gen_if.slave bus
);

  mode_e              mode_q;
  logic               fb;
  logic [10:0]        box_x;
  logic [10:0]        box_y;
  logic [10:0]        px;
  logic [10:0]        py;
  logic [2:0]         bar;
  logic               in_box;
  logic [2:0]         rgb;
  logic [COLOR_W-1:0] red_q;
  logic [COLOR_W-1:0] green_q;
  logic [COLOR_W-1:0] blue_q;
  logic               tick_q;

  assign px = {1'b0, bus.pixel_x};
  assign py = {1'b0, bus.pixel_y};
  assign fb = (px == 11'd0) && (py == 11'(V_VIDEO));

  vga_box_mover #(
    .LIMIT (H_VIDEO - BOX_SIZE),
    .STEP  (BOX_STEP)
  ) u_box_x (
    .clk_0   (clk_0),
    .rst     (rst),
    .step_en (fb),
    .pos     (box_x)
  );

  vga_box_mover #(
    .LIMIT (V_VIDEO - BOX_SIZE),
    .STEP  (BOX_STEP)
  ) u_box_y (
    .clk_0   (clk_0),
    .rst     (rst),
    .step_en (fb),
    .pos     (box_y)
  );

  // bar index = number of constant thresholds passed
  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++) begin
      if (px >= 11'(k * H_VIDEO / 8)) begin
        bar = bar + 3'd1;
      end
    end
  end

  assign in_box = (px >= box_x)
               && (px < box_x + 11'(BOX_SIZE))
               && (py >= box_y)
               && (py < box_y + 11'(BOX_SIZE));

  always_comb begin
    rgb = '0;
    if (bus.video_on) begin
      unique case (mode_q)
        MODE_SOLID: rgb = 3'b111;
        MODE_BARS:  rgb = BAR_RGB[bar];
        MODE_CHECK: rgb = (bus.pixel_x[CHECK_LOG2]
                         ^ bus.pixel_y[CHECK_LOG2])
                          ? 3'b000 : 3'b111;
        MODE_BOX:   rgb = in_box ? 3'b111 : 3'b000;
        default:    rgb = '0;
      endcase
    end
  end

  always_ff @(posedge clk_0) begin
    if (!rst) begin
      mode_q  <= MODE_SOLID;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      tick_q  <= 1'b0;
    end else begin
      if (fb) begin
        mode_q <= mode_e'(bus.mode_sel);
      end
      red_q   <= {COLOR_W{rgb[2]}};
      green_q <= {COLOR_W{rgb[1]}};
      blue_q  <= {COLOR_W{rgb[0]}};
      tick_q  <= fb;
    end
  end

  assign bus.red        = red_q;
  assign bus.green      = green_q;
  assign bus.blue       = blue_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: vector table plus bounce/reset sequences,
// expected {R,G,B,tick} queued at drive time and popped after the edge.
module tb_vga_pattern_gen;

  logic clk_0 = 1'b0;
  logic rst   = 1'b0;

  always #20 clk_0 = ~clk_0;

  vga_pattern_gen_if #(.COLOR_W(1)) bus ();

  vga_pattern_gen #(.COLOR_W(1)) dut (
    .clk_0 (clk_0),
    .rst   (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    int         px;
    int         py;
    bit         von;
    int         msel;
    logic [2:0] rgb;
    bit         tick;
    string      name;
  } vec_t;

  typedef struct {
    logic [3:0] v;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_out();
    exp_t       e;
    logic [3:0] got;
    got = {bus.red, bus.green, bus.blue, bus.frame_tick};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %b required nothing", got);
    end else begin
      e = sb.pop_front();
      if (got !== e.v) begin
        errors++;
        $display("FAIL %s: got rgbt=%b required %b",
                 e.name, got, e.v);
      end
    end
  endtask

  task automatic step(input int px, input int py, input bit von,
                      input int msel, input bit r,
                      input logic [2:0] e_rgb, input bit e_tick,
                      input string nm);
    exp_t e;
    @(negedge clk_0);
    rst          = r;
    bus.pixel_x  = 10'(px);
    bus.pixel_y  = 10'(py);
    bus.video_on = von;
    bus.mode_sel = 2'(msel);
    e.v    = {e_rgb, e_tick};
    e.name = nm;
    sb.push_back(e);
    @(posedge clk_0);
    #1;
    check_out();
  endtask

  task automatic frames(input int n, input int msel);
    for (int i = 0; i < n; i++) begin
      step(0, 480, 0, msel, 1, 3'b000, 1, "fb");
    end
  endtask

  task automatic probe(input int x, input int y, input bit white,
                       input string nm);
    step(x, y, 1, 3, 1, white ? 3'b111 : 3'b000, 0, nm);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[$];

  initial begin
    bus.pixel_x  = '0;
    bus.pixel_y  = '0;
    bus.video_on = 1'b0;
    bus.mode_sel = '0;

    tbl.push_back('{100, 100, 1, 0, 3'b111, 0, "solid"});
    tbl.push_back('{100, 100, 0, 0, 3'b000, 0, "solid_blank"});
    tbl.push_back('{85,  200, 1, 1, 3'b111, 0, "defer_white"});
    tbl.push_back('{639, 200, 1, 1, 3'b111, 0, "defer_white2"});
    tbl.push_back('{1,   480, 0, 1, 3'b000, 0, "near_fb"});
    tbl.push_back('{0,   480, 0, 1, 3'b000, 1, "fb_bars"});
    tbl.push_back('{85,  10,  1, 0, 3'b110, 0, "bar_yellow"});
    tbl.push_back('{639, 10,  1, 0, 3'b000, 0, "bar_black_end"});
    tbl.push_back('{0,   10,  1, 0, 3'b111, 0, "bar_white0"});
    tbl.push_back('{79,  10,  1, 0, 3'b111, 0, "bar_white79"});
    tbl.push_back('{80,  10,  1, 0, 3'b110, 0, "bar_yellow80"});
    tbl.push_back('{160, 10,  1, 0, 3'b011, 0, "bar_cyan"});
    tbl.push_back('{240, 10,  1, 0, 3'b010, 0, "bar_green"});
    tbl.push_back('{320, 10,  1, 0, 3'b101, 0, "bar_magenta"});
    tbl.push_back('{400, 10,  1, 0, 3'b100, 0, "bar_red"});
    tbl.push_back('{559, 10,  1, 0, 3'b001, 0, "bar_blue559"});
    tbl.push_back('{560, 10,  1, 0, 3'b000, 0, "bar_black560"});
    tbl.push_back('{85,  10,  0, 0, 3'b000, 0, "bar_blank"});
    tbl.push_back('{0,   480, 0, 2, 3'b000, 1, "fb_check"});
    tbl.push_back('{0,   0,   1, 2, 3'b111, 0, "chk_0_0"});
    tbl.push_back('{16,  0,   1, 2, 3'b000, 0, "chk_16_0"});
    tbl.push_back('{16,  16,  1, 2, 3'b111, 0, "chk_16_16"});
    tbl.push_back('{15,  15,  1, 2, 3'b111, 0, "chk_15_15"});
    tbl.push_back('{0,   16,  1, 2, 3'b000, 0, "chk_0_16"});
    tbl.push_back('{32,  0,   1, 2, 3'b111, 0, "chk_32_0"});
    tbl.push_back('{0,   480, 0, 0, 3'b000, 1, "fb_solid"});
    tbl.push_back('{16,  0,   1, 0, 3'b111, 0, "solid_again"});

    // reset held 3 clocks, including a cycle sitting on fb
    step(100, 100, 1, 2, 0, 3'b000, 0, "rst_0");
    step(100, 100, 1, 2, 0, 3'b000, 0, "rst_1");
    step(0,   480, 0, 2, 0, 3'b000, 0, "rst_fb");

    foreach (tbl[i]) begin
      step(tbl[i].px, tbl[i].py, tbl[i].von, tbl[i].msel, 1,
           tbl[i].rgb, tbl[i].tick, tbl[i].name);
    end

    // bounce sequence from a clean origin
    step(300, 250, 1, 3, 0, 3'b000, 0, "box_rst");
    frames(1, 3);
    probe(4, 4, 1, "f1_tl");
    probe(3, 4, 0, "f1_left");
    probe(35, 35, 1, "f1_br");
    probe(36, 4, 0, "f1_right");
    probe(4, 36, 0, "f1_below");
    frames(111, 3);
    probe(448, 448, 1, "f112_tl");
    probe(448, 447, 0, "f112_above");
    probe(479, 479, 1, "f112_br");
    frames(1, 3);
    probe(452, 444, 1, "f113_tl");
    probe(452, 443, 0, "f113_above");
    probe(452, 475, 1, "f113_bot");
    probe(452, 476, 0, "f113_below");
    frames(38, 3);
    probe(604, 292, 1, "f151_tl");
    probe(603, 292, 0, "f151_left");
    probe(635, 292, 1, "f151_right");
    probe(636, 292, 0, "f151_past");
    frames(1, 3);
    probe(608, 288, 1, "f152_tl");
    probe(607, 288, 0, "f152_left");
    probe(639, 288, 1, "f152_edge");
    frames(1, 3);
    probe(604, 284, 1, "f153_tl");
    probe(603, 284, 0, "f153_left");
    probe(636, 284, 0, "f153_past");

    // mid-frame reset with the box away from the origin
    step(300, 250, 1, 3, 0, 3'b000, 0, "box_rst2");
    frames(50, 3);
    probe(200, 200, 1, "f50_tl");
    probe(199, 200, 0, "f50_left");
    step(300, 250, 1, 3, 0, 3'b000, 0, "mid_rst");
    step(300, 250, 1, 3, 1, 3'b111, 0, "post_rst_solid");
    step(0,   0,   1, 3, 1, 3'b111, 0, "post_rst_solid2");
    frames(1, 3);
    probe(4, 4, 1, "post_rst_box");
    probe(3, 4, 0, "post_rst_left");
    probe(200, 200, 0, "post_rst_old");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
